// File: rtl/lane_mem_lsu.sv
// Per-lane load/store sequencer driving mem_dualport; serializes same-address stores in lane order.
// Optional store readback check enabled by defining LANE_MEM_LSU_STORE_VERIFY_EN (adds o_store_err).
module lane_mem_lsu #(
    parameter int LANES      = 4,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_req_valid,
    output logic                                 o_req_ready,
    input  logic                                 i_req_store,
    input  logic [LANES-1:0]                     i_req_mask,
    input  logic [LANES-1:0][ADDR_WIDTH-1:0]     i_req_addr_a,
    input  logic [LANES-1:0][ADDR_WIDTH-1:0]     i_req_addr_b,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]     i_req_wdata,
    output logic [LANES-1:0]                     o_mem_write_en,
    output logic [LANES-1:0][ADDR_WIDTH-1:0]     o_mem_write_addr,
    output logic [LANES-1:0][DATA_WIDTH-1:0]     o_mem_write_data,
    output logic [LANES-1:0][ADDR_WIDTH-1:0]     o_mem_read_addr_a,
    output logic [LANES-1:0][ADDR_WIDTH-1:0]     o_mem_read_addr_b,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]     i_mem_read_data_a,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]     i_mem_read_data_b,
    output logic                                 o_rsp_valid,
    input  logic                                 i_rsp_ready,
    output logic                                 o_rsp_store,
    output logic [LANES-1:0]                     o_rsp_mask,
    output logic [LANES-1:0][DATA_WIDTH-1:0]     o_rsp_data_a,
    output logic [LANES-1:0][DATA_WIDTH-1:0]     o_rsp_data_b,
    output logic                                 o_busy
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
    ,
    output logic [LANES-1:0]                     o_store_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
        S_VERIFY,
`endif
        S_RESP
    } state_t;

    state_t                              r_state;
    state_t                              w_next;
    logic                                r_store;
    logic [LANES-1:0]                    r_mask;
    logic [LANES-1:0]                    r_pend;
    logic [LANES-1:0][ADDR_WIDTH-1:0]    r_addr_a;
    logic [LANES-1:0][ADDR_WIDTH-1:0]    r_addr_b;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_wdata;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_rsp_data_a;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_rsp_data_b;
    logic [LANES-1:0]                    w_issue;

    // A pending lane issues only if no lower pending lane targets the same word this pass.
    always_comb begin
        w_issue = '0;
        for (int i = 0; i < LANES; i++) begin
            w_issue[i] = r_pend[i];
            for (int j = 0; j < i; j++) begin
                if (r_pend[j] && (r_addr_a[j] == r_addr_a[i])) begin
                    w_issue[i] = 1'b0;
                end
            end
        end
    end

`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
    logic [LANES-1:0] r_store_err;
    logic [LANES-1:0] w_err;

    // Only the highest active lane of an address owns the final value, so only it is checked.
    always_comb begin
        w_err = '0;
        for (int i = 0; i < LANES; i++) begin
            w_err[i] = r_mask[i] && (i_mem_read_data_a[i] != r_wdata[i]);
            for (int j = i + 1; j < LANES; j++) begin
                if (r_mask[j] && (r_addr_a[j] == r_addr_a[i])) begin
                    w_err[i] = 1'b0;
                end
            end
        end
    end

    assign o_store_err = r_store_err;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_req_valid) w_next = i_req_store ? S_STORE : S_LOAD;
            S_LOAD:   w_next = S_RESP;
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
            S_STORE:  if (r_pend == '0) w_next = S_VERIFY;
            S_VERIFY: w_next = S_RESP;
`else
            S_STORE:  if (r_pend == '0) w_next = S_RESP;
`endif
            S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_store      <= 1'b0;
            r_mask       <= '0;
            r_pend       <= '0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_wdata      <= '0;
            r_rsp_data_a <= '0;
            r_rsp_data_b <= '0;
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
            r_store_err  <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_store      <= i_req_store;
                        r_mask       <= i_req_mask;
                        r_pend       <= i_req_store ? i_req_mask : '0;
                        r_addr_a     <= i_req_addr_a;
                        r_addr_b     <= i_req_addr_b;
                        r_wdata      <= i_req_wdata;
                        r_rsp_data_a <= '0;
                        r_rsp_data_b <= '0;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_rsp_data_a[i] <= r_mask[i] ? i_mem_read_data_a[i] : '0;
                        r_rsp_data_b[i] <= r_mask[i] ? i_mem_read_data_b[i] : '0;
                    end
                end
                S_STORE: r_pend <= r_pend & ~w_issue;
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
                S_VERIFY: r_store_err <= w_err;
                S_RESP: if (i_rsp_ready) r_store_err <= '0;
`endif
                default: ;
            endcase
        end
    end

    assign o_req_ready       = (r_state == S_IDLE) && rst_n;
    assign o_busy            = (r_state != S_IDLE);
    assign o_mem_write_en    = (r_state == S_STORE) ? w_issue : '0;
    assign o_mem_write_addr  = r_addr_a;
    assign o_mem_write_data  = r_wdata;
    assign o_mem_read_addr_a = r_addr_a;
    assign o_mem_read_addr_b = r_addr_b;
    assign o_rsp_valid       = (r_state == S_RESP);
    assign o_rsp_store       = r_store;
    assign o_rsp_mask        = r_mask;
    assign o_rsp_data_a      = r_rsp_data_a;
    assign o_rsp_data_b      = r_rsp_data_b;

endmodule

// File: tb/tb_lane_mem_lsu.sv
// Scoreboard bench for lane_mem_lsu with a behavioural dual-port memory and a reference memory model.
// Define LANE_MEM_LSU_STORE_VERIFY_EN to also exercise the store readback check.
module tb_lane_mem_lsu;

    localparam int LANES     = 4;
    localparam int MEM_DEPTH = 64;
    localparam int AW        = 6;
    localparam int DW        = 32;
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
    localparam int VERIFY_EXTRA = 1;
`else
    localparam int VERIFY_EXTRA = 0;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        reqValid = 1'b0;
    logic                        reqReady;
    logic                        reqStore = 1'b0;
    logic [LANES-1:0]            reqMask = '0;
    logic [LANES-1:0][AW-1:0]    reqAddrA = '0;
    logic [LANES-1:0][AW-1:0]    reqAddrB = '0;
    logic [LANES-1:0][DW-1:0]    reqWdata = '0;
    logic [LANES-1:0]            memWriteEn;
    logic [LANES-1:0][AW-1:0]    memWriteAddr;
    logic [LANES-1:0][DW-1:0]    memWriteData;
    logic [LANES-1:0][AW-1:0]    memReadAddrA;
    logic [LANES-1:0][AW-1:0]    memReadAddrB;
    logic [LANES-1:0][DW-1:0]    memReadDataA;
    logic [LANES-1:0][DW-1:0]    memReadDataB;
    logic                        rspValid;
    logic                        rspReady = 1'b0;
    logic                        rspStore;
    logic [LANES-1:0]            rspMask;
    logic [LANES-1:0][DW-1:0]    rspDataA;
    logic [LANES-1:0][DW-1:0]    rspDataB;
    logic                        busy;
    logic [LANES-1:0]            storeErrObs;
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
    logic [LANES-1:0]            storeErr;
    assign storeErrObs = storeErr;
`else
    assign storeErrObs = '0;
`endif

    lane_mem_lsu #(.LANES(LANES), .MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (reqValid),
        .o_req_ready      (reqReady),
        .i_req_store      (reqStore),
        .i_req_mask       (reqMask),
        .i_req_addr_a     (reqAddrA),
        .i_req_addr_b     (reqAddrB),
        .i_req_wdata      (reqWdata),
        .o_mem_write_en   (memWriteEn),
        .o_mem_write_addr (memWriteAddr),
        .o_mem_write_data (memWriteData),
        .o_mem_read_addr_a(memReadAddrA),
        .o_mem_read_addr_b(memReadAddrB),
        .i_mem_read_data_a(memReadDataA),
        .i_mem_read_data_b(memReadDataB),
        .o_rsp_valid      (rspValid),
        .i_rsp_ready      (rspReady),
        .o_rsp_store      (rspStore),
        .o_rsp_mask       (rspMask),
        .o_rsp_data_a     (rspDataA),
        .o_rsp_data_b     (rspDataB),
        .o_busy           (busy)
`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
        ,
        .o_store_err      (storeErr)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural mem_dualport: registered writes, combinational reads, optional lane-2 readback corruption.
    logic [DW-1:0] mem [MEM_DEPTH];
    logic          memClear = 1'b1;
    logic          corruptLane2 = 1'b0;

    always @(posedge clk) begin
        if (memClear) begin
            for (int k = 0; k < MEM_DEPTH; k++) mem[k] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (memWriteEn[l]) mem[memWriteAddr[l]] <= memWriteData[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            memReadDataA[l] = mem[memReadAddrA[l]] ^ ((corruptLane2 && l == 2) ? 32'h0000_FFFF : 32'h0);
            memReadDataB[l] = mem[memReadAddrB[l]];
        end
    end

    logic [LANES-1:0] weQ[$];
    int               writeCount = 0;

    always @(negedge clk) begin
        if (memWriteEn != '0) begin
            weQ.push_back(memWriteEn);
            writeCount++;
        end
    end

    typedef struct packed {
        logic              store;
        logic [LANES-1:0]  mask;
        logic [127:0]      dataA;
        logic [127:0]      dataB;
        logic [LANES-1:0]  err;
    } rsp_t;

    rsp_t          expQ[$];
    logic [DW-1:0] refMem [MEM_DEPTH];
    int            vectorCount = 0;
    int            missCount = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int storeLat(input logic [LANES-1:0] m, input logic [LANES-1:0][AW-1:0] a);
        int maxMult = 0;
        for (int i = 0; i < LANES; i++) begin
            int cnt = 0;
            if (m[i]) begin
                for (int j = 0; j < LANES; j++) if (m[j] && a[j] == a[i]) cnt++;
                if (cnt > maxMult) maxMult = cnt;
            end
        end
        return maxMult + 2 + VERIFY_EXTRA;
    endfunction

    task automatic driveReq(input logic st, input logic [LANES-1:0] m, input logic [LANES-1:0][AW-1:0] a,
                            input logic [LANES-1:0][AW-1:0] b, input logic [LANES-1:0][DW-1:0] w);
        int guard = 0;
        @(negedge clk);
        while (!reqReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("req_ready_idle", 128'(reqReady), 128'(1'b1));
        weQ.delete();
        reqValid = 1'b1;
        reqStore = st;
        reqMask  = m;
        reqAddrA = a;
        reqAddrB = b;
        reqWdata = w;
        @(posedge clk);
        #1 reqValid = 1'b0;
    endtask

    task automatic collectResponse(input int expLat, input int hold);
        int      lat = 0;
        int      startWrites;
        rsp_t    exp;
        logic [127:0] snapA;
        logic [LANES-1:0] snapMask;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (rspValid) break;
        end
        checkOutput("rsp_latency", 128'(lat), 128'(expLat));
        exp = expQ.pop_front();
        if (!rspValid) return;
        snapA       = rspDataA;
        snapMask    = rspMask;
        startWrites = writeCount;
        for (int h = 0; h < hold; h++) begin
            checkOutput("req_ready_in_resp", 128'(reqReady), 128'(1'b0));
            @(negedge clk);
            checkOutput("rsp_hold_valid", 128'(rspValid), 128'(1'b1));
            checkOutput("rsp_hold_data", rspDataA, snapA);
            checkOutput("rsp_hold_mask", 128'(rspMask), 128'(snapMask));
        end
        if (hold > 0) checkOutput("no_writes_in_resp", 128'(writeCount - startWrites), 128'(0));
        checkOutput("rsp_store", 128'(rspStore), 128'(exp.store));
        checkOutput("rsp_mask", 128'(rspMask), 128'(exp.mask));
        checkOutput("rsp_data_a", rspDataA, exp.dataA);
        checkOutput("rsp_data_b", rspDataB, exp.dataB);
        checkOutput("store_err", 128'(storeErrObs), 128'(exp.err));
        rspReady = 1'b1;
        @(posedge clk);
        #1 rspReady = 1'b0;
        @(negedge clk);
        checkOutput("rsp_valid_drop", 128'(rspValid), 128'(1'b0));
        checkOutput("busy_after_rsp", 128'(busy), 128'(1'b0));
    endtask

    // Builds the expected response from the reference memory, then runs one full transaction.
    task automatic applyStimulus(input logic st, input logic [LANES-1:0] m, input logic [LANES-1:0][AW-1:0] a,
                                 input logic [LANES-1:0][AW-1:0] b, input logic [LANES-1:0][DW-1:0] w,
                                 input int hold);
        rsp_t exp;
        int   lat;
        exp = '0;
        exp.store = st;
        exp.mask  = m;
        if (st) begin
            for (int l = 0; l < LANES; l++) if (m[l]) refMem[a[l]] = w[l];
            if (corruptLane2 && m[2]) begin
                exp.err[2] = 1'b1;
                for (int j = 3; j < LANES; j++) if (m[j] && a[j] == a[2]) exp.err[2] = 1'b0;
            end
            lat = storeLat(m, a);
        end else begin
            for (int l = 0; l < LANES; l++) begin
                exp.dataA[l*DW +: DW] = m[l] ? refMem[a[l]] : '0;
                exp.dataB[l*DW +: DW] = m[l] ? refMem[b[l]] : '0;
            end
            lat = 2;
        end
        expQ.push_back(exp);
        driveReq(st, m, a, b, w);
        collectResponse(lat, hold);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [LANES-1:0][AW-1:0] a;
        logic [LANES-1:0][AW-1:0] b;
        logic [LANES-1:0][DW-1:0] w;
        logic [LANES-1:0]         m;
        bit                       sawRsp;

        for (int k = 0; k < MEM_DEPTH; k++) refMem[k] = '0;

        #1;
        checkOutput("reset_req_ready", 128'(reqReady), 128'(1'b0));
        checkOutput("reset_busy", 128'(busy), 128'(1'b0));
        checkOutput("reset_rsp_valid", 128'(rspValid), 128'(1'b0));
        checkOutput("reset_write_en", 128'(memWriteEn), 128'(0));
        repeat (2) @(negedge clk);
        memClear = 1'b0;
        rst_n    = 1'b1;
        #1 checkOutput("post_reset_req_ready", 128'(reqReady), 128'(1'b1));

        // Distinct-address store: one pass, then load back.
        for (int l = 0; l < LANES; l++) begin
            a[l] = AW'(8 + l);
            b[l] = AW'(8 + l);
            w[l] = 32'h200 + l;
        end
        applyStimulus(1'b1, 4'hF, a, b, w, 0);
        checkOutput("single_pass_count", 128'(weQ.size()), 128'(1));
        if (weQ.size() > 0) checkOutput("single_pass_en", 128'(weQ[0]), 128'(4'hF));
        applyStimulus(1'b0, 4'hF, a, b, w, 0);

        // All lanes to one address: four ordered passes, last lane wins.
        for (int l = 0; l < LANES; l++) begin
            a[l] = AW'(20);
            w[l] = 32'hA0 + l;
        end
        applyStimulus(1'b1, 4'hF, a, b, w, 0);
        checkOutput("conflict_pass_count", 128'(weQ.size()), 128'(4));
        for (int p = 0; p < 4 && p < weQ.size(); p++) begin
            checkOutput("conflict_pass_en", 128'(weQ[p]), 128'(4'b0001 << p));
        end
        applyStimulus(1'b0, 4'hF, a, a, w, 0);

        // Populate words 1..8, then a partially masked load held off by rsp_ready.
        for (int l = 0; l < LANES; l++) begin
            a[l] = AW'(1 + l);
            w[l] = 32'hC100 + l;
        end
        applyStimulus(1'b1, 4'hF, a, b, w, 0);
        for (int l = 0; l < LANES; l++) begin
            a[l] = AW'(5 + l);
            w[l] = 32'hC500 + l;
        end
        applyStimulus(1'b1, 4'hF, a, b, w, 0);
        for (int l = 0; l < LANES; l++) begin
            a[l] = AW'(1 + l);
            b[l] = AW'(5 + l);
        end
        applyStimulus(1'b0, 4'b0101, a, b, w, 5);

        // Empty store mask: no writes, shortest store response.
        applyStimulus(1'b1, 4'h0, a, b, w, 0);
        checkOutput("empty_mask_writes", 128'(weQ.size()), 128'(0));

        // Randomized mix over a small address window to provoke collisions.
        for (int t = 0; t < 8; t++) begin
            for (int l = 0; l < LANES; l++) begin
                a[l] = AW'($urandom_range(40, 43));
                b[l] = AW'($urandom_range(40, 43));
                w[l] = $urandom;
            end
            m = LANES'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), m, a, b, w, $urandom_range(0, 2));
        end

        // Reset during the second pass of a colliding store.
        for (int l = 0; l < LANES; l++) begin
            a[l] = AW'(30);
            w[l] = 32'hB0 + l;
        end
        driveReq(1'b1, 4'hF, a, b, w);
        @(negedge clk);
        checkOutput("abort_pass1_en", 128'(memWriteEn), 128'(4'b0001));
        @(negedge clk);
        checkOutput("abort_pass2_en", 128'(memWriteEn), 128'(4'b0010));
        rst_n = 1'b0;
        #1;
        checkOutput("abort_write_en", 128'(memWriteEn), 128'(0));
        checkOutput("abort_busy", 128'(busy), 128'(1'b0));
        checkOutput("abort_rsp_valid", 128'(rspValid), 128'(1'b0));
        checkOutput("abort_rsp_mask", 128'(rspMask), 128'(0));
        refMem[30] = 32'hB0;
        @(negedge clk);
        rst_n  = 1'b1;
        sawRsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rspValid) sawRsp = 1'b1;
        end
        checkOutput("abort_no_response", 128'(sawRsp), 128'(1'b0));
        applyStimulus(1'b0, 4'hF, a, a, w, 0);

`ifdef LANE_MEM_LSU_STORE_VERIFY_EN
        // Corrupted lane-2 readback must flag only lane 2.
        for (int l = 0; l < LANES; l++) begin
            a[l] = AW'(12 + l);
            w[l] = 32'hD000 + l;
        end
        corruptLane2 = 1'b1;
        applyStimulus(1'b1, 4'hF, a, b, w, 1);
        corruptLane2 = 1'b0;
        applyStimulus(1'b1, 4'hF, a, b, w, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
